// File: rtl/dmem_responder.sv
// Data-memory responder: accepts one word access per transaction, waits a fixed
// latency, commits against the local storage array and holds the response until taken.
module dmem_responder #(
  parameter int WORD    = 32,
  parameter int DEPTH   = 1024,
  parameter int LATENCY = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_we,
  input  logic [WORD-1:0] req_addr,
  input  logic [WORD-1:0] req_wdata,
  input  logic [3:0]      req_be,
  output logic            resp_valid,
  input  logic            resp_ready,
  output logic [WORD-1:0] resp_rdata,
  output logic            resp_err,
  output logic [31:0]     txn_count
);
  localparam int IDXW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  typedef struct packed {
    logic            we;
    logic [WORD-1:0] addr;
    logic [WORD-1:0] wdata;
    logic [3:0]      be;
  } req_t;

  logic [1:0]      state;
  logic [3:0]      cnt;
  req_t            reqQ;
  logic            respValid;
  logic            respErr;
  logic [WORD-1:0] respRdata;
  logic [31:0]     txnCount;

  logic [WORD-1:0] mem [DEPTH];

  logic            accErr;
  logic [IDXW-1:0] idx;
  logic            commit;
  logic            commitWr;

  assign idx      = reqQ.addr[IDXW+1:2];
  assign accErr   = (|reqQ.addr[1:0]) | (reqQ.addr[WORD-1:2] >= (WORD-2)'(DEPTH));
  assign commit   = (state == BUSY) && (cnt == 4'd0);
  assign commitWr = commit && reqQ.we && !accErr;

  // Gated by reset so the port reads 0 while reset is held, even though state is IDLE.
  assign req_ready  = reset && (state == IDLE);
  assign resp_valid = respValid;
  assign resp_err   = respErr;
  assign resp_rdata = respRdata;
  assign txn_count  = txnCount;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      cnt       <= '0;
      reqQ      <= '0;
      respValid <= 1'b0;
      respErr   <= 1'b0;
      respRdata <= '0;
      txnCount  <= '0;
    end else begin
      case (state)
        IDLE: if (req_valid) begin
          reqQ  <= '{we: req_we, addr: req_addr, wdata: req_wdata, be: req_be};
          cnt   <= 4'(LATENCY - 1);
          state <= BUSY;
        end
        BUSY: if (cnt == 4'd0) begin
          respValid <= 1'b1;
          respErr   <= accErr;
          respRdata <= (!accErr && !reqQ.we) ? mem[idx] : '0;
          state     <= RESP;
        end else begin
          cnt <= cnt - 4'd1;
        end
        RESP: if (resp_ready) begin
          respValid <= 1'b0;
          respErr   <= 1'b0;
          respRdata <= '0;
          txnCount  <= txnCount + 32'd1;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Storage is deliberately left out of reset; a write only lands on its commit edge.
  always_ff @(posedge clk) begin
    if (commitWr) begin
      for (int i = 0; i < 4; i++)
        if (reqQ.be[i]) mem[idx][8*i +: 8] <= reqQ.wdata[8*i +: 8];
    end
  end
endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: directed cases plus randomized traffic against a word-array model.
module tb_dmem_responder;
  localparam int DEPTH = 1024;
  localparam int LAT   = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic [3:0]  req_be = '0;
  logic        resp_valid;
  logic        resp_ready = 1'b0;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [31:0] txn_count;

  int checks = 0;
  int errors = 0;
  int expTxn = 0;
  logic [31:0] model [DEPTH];

  dmem_responder #(.WORD(32), .DEPTH(DEPTH), .LATENCY(LAT)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
    .resp_err(resp_err), .txn_count(txn_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One full transaction: expectations come from the model before the request is issued.
  task automatic txn(input bit we, input logic [31:0] addr, input logic [31:0] wd,
                     input logic [3:0] be, input int stall);
    int n;
    bit expE;
    logic [31:0] expD;
    expE = (addr[1:0] != 2'b00) || ((addr >> 2) >= DEPTH);
    expD = '0;
    if (!expE) begin
      if (we) begin
        for (int i = 0; i < 4; i++)
          if (be[i]) model[addr >> 2][8*i +: 8] = wd[8*i +: 8];
      end else begin
        expD = model[addr >> 2];
      end
    end
    @(negedge clk);
    n = 0;
    while (!req_ready && n < 50) begin @(negedge clk); n++; end
    chk("req_ready_idle", {31'd0, req_ready}, 32'd1);
    req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wd; req_be = be;
    @(posedge clk); #1;
    req_valid = 1'b0;
    req_we = 1'($urandom); req_addr = $urandom; req_wdata = $urandom; req_be = 4'($urandom);
    n = 0;
    @(negedge clk);
    while (!resp_valid && n < 50) begin @(negedge clk); n++; end
    chk("latency", n, LAT);
    chk("req_ready_resp", {31'd0, req_ready}, 32'd0);
    for (int s = 0; s < stall; s++) begin
      req_valid = (s == 1);
      @(negedge clk);
      req_valid = 1'b0;
      chk("stall_valid", {31'd0, resp_valid}, 32'd1);
      chk("stall_rdata", resp_rdata, expD);
      chk("stall_err", {31'd0, resp_err}, {31'd0, expE});
      chk("stall_req_ready", {31'd0, req_ready}, 32'd0);
    end
    chk("rdata", resp_rdata, expD);
    chk("err", {31'd0, resp_err}, {31'd0, expE});
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
    expTxn++;
    chk("resp_valid_clr", {31'd0, resp_valid}, 32'd0);
    chk("rdata_clr", resp_rdata, 32'd0);
    chk("txn_count", txn_count, expTxn);
    chk("req_ready_after", {31'd0, req_ready}, 32'd1);
  endtask

  function automatic logic [31:0] randAddr();
    int k;
    k = $urandom_range(0, 9);
    if (k == 0) return {26'($urandom_range(0, 15)), 4'($urandom_range(0, 15)) | 4'h1, 2'b00} | 32'($urandom_range(1, 3));
    if (k == 1) return 32'((DEPTH + $urandom_range(0, 100)) * 4);
    return 32'($urandom_range(0, 15) * 4);
  endfunction

  initial begin
    int n;
    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_req_ready", {31'd0, req_ready}, 32'd0);
    chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    chk("rst_txn", txn_count, 32'd0);
    reset = 1'b1;
    @(negedge clk);
    chk("post_rst_req_ready", {31'd0, req_ready}, 32'd1);
    chk("post_rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    chk("post_rst_txn", txn_count, 32'd0);

    // Directed sequence
    txn(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 0);
    txn(1'b0, 32'h10, 32'h0, 4'h0, 0);
    chk("txn_after_two", txn_count, 32'd2);
    txn(1'b1, 32'h10, 32'h11223344, 4'b0101, 0);
    txn(1'b0, 32'h10, 32'h0, 4'h0, 0);
    chk("partial_model", model[4], 32'hDE22BE44);
    txn(1'b0, 32'h13, 32'h0, 4'h0, 0);
    txn(1'b0, 32'(DEPTH * 4), 32'h0, 4'h0, 0);
    txn(1'b1, 32'h14, 32'h55555555, 4'hF, 0);
    txn(1'b1, 32'h14, 32'hFFFFFFFF, 4'h0, 0);
    txn(1'b1, 32'h17, 32'hAAAAAAAA, 4'hF, 0);
    txn(1'b0, 32'h14, 32'h0, 4'h0, 0);
    txn(1'b0, 32'h10, 32'h0, 4'h0, 5);

    // Random traffic over a small initialized window plus fault addresses
    for (int a = 0; a < 16; a++) txn(1'b1, 32'(a * 4), $urandom, 4'hF, 0);
    for (int t = 0; t < 200; t++)
      txn(1'($urandom), randAddr(), $urandom, 4'($urandom), $urandom_range(0, 3));

    // Reset while a write is in flight
    txn(1'b1, 32'h20, 32'h12345678, 4'hF, 0);
    @(negedge clk);
    n = 0;
    while (!req_ready && n < 50) begin @(negedge clk); n++; end
    req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h20; req_wdata = 32'hCAFEF00D; req_be = 4'hF;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("midrst_req_ready", {31'd0, req_ready}, 32'd0);
    chk("midrst_txn", txn_count, 32'd0);
    repeat (2) @(negedge clk);
    chk("midrst_resp_valid", {31'd0, resp_valid}, 32'd0);
    reset = 1'b1;
    expTxn = 0;
    txn(1'b0, 32'h20, 32'h0, 4'h0, 0);
    chk("midrst_old_data", model[8], 32'h12345678);
    chk("midrst_txn_final", txn_count, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
